// File: rtl/fetch_queue_if.sv
// Fetch/decode boundary bundle: instruction-memory port, decode-side
// control (pop, redirect, exception entry, eret) and the prefetch FIFO head.
`timescale 1ns/1ps

interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      i_addr;
    logic [31:0]      i_instr;
    logic             d_ready;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             req;
    logic             eret;
    logic [31:0]      epc;
    logic             q_valid;
    logic [31:0]      q_pc;
    logic [31:0]      q_instr;
    logic [4:0]       q_exccode;
    logic             q_bd;
    logic [CNT_W-1:0] q_count;

    // Fetch stage side: owns the PC and the FIFO head.
    modport master (
        output i_addr,
        input  i_instr,
        input  d_ready, redirect, redirect_pc, req, eret, epc,
        output q_valid, q_pc, q_instr, q_exccode, q_bd, q_count
    );

    // Memory/decode side.
    modport slave (
        input  i_addr,
        output i_instr,
        output d_ready, redirect, redirect_pc, req, eret, epc,
        input  q_valid, q_pc, q_instr, q_exccode, q_bd, q_count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, fetches one word per cycle into a
// DEPTH-entry prefetch FIFO, tags address errors, and handles branch
// redirect (keeping exactly one delay slot), exception entry and eret.
`timescale 1ns/1ps

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_LOW   = 32'h0000_3000,
    parameter logic [31:0] PC_HIGH  = 32'h0000_6ffc,
    parameter logic [31:0] HANDLER  = 32'h0000_4180,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } entry_t;

    logic [31:0]      pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    entry_t mem    [DEPTH];
    logic   bd_mem [DEPTH];

    logic             q_valid;
    logic             full;
    logic             pop;
    logic             fetch;
    logic             adel;
    logic             do_flush;
    logic             do_redir;
    logic             keep_one;
    logic             push;
    logic [PTR_W-1:0] rd_next;
    entry_t           fetch_ent;

    assign q_valid  = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = bus.d_ready && q_valid;
    assign fetch    = !full || pop;
    assign rd_next  = rd_ptr + PTR_W'(1);

    // Misaligned, below or above the legal window (covers PC wrap-around).
    assign adel      = (pc[1:0] != 2'b00) || (pc < PC_LOW) || (pc > PC_HIGH);
    assign fetch_ent = {pc, (adel ? NOP : bus.i_instr), (adel ? EXC_ADEL : EXC_NONE)};

    // req and eret flush everything; a redirect only counts with a real pop.
    assign do_flush = bus.req || bus.eret;
    assign do_redir = !do_flush && pop && bus.redirect;
    // After popping the branch, an older fetched entry survives as the delay slot.
    assign keep_one = do_redir && (count > CNT_W'(1));
    // The fetched word is written unless flushed or superseded by a kept delay slot.
    assign push     = !reset && !do_flush && fetch && !keep_one;

    // FIFO storage writes: new fetch at the tail, delay-slot mark on a kept entry.
    // NOTE: storage has no reset; count alone decides validity and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]    <= fetch_ent;
            bd_mem[wr_ptr] <= do_redir;
        end
        if (keep_one) begin
            bd_mem[rd_next] <= 1'b1;
        end
    end

    // PC, pointers and occupancy, in priority order reset > req > eret > redirect > normal.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= PC_RESET;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (do_flush) begin
            pc     <= bus.req ? HANDLER : bus.epc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (do_redir) begin
            pc     <= bus.redirect_pc;
            rd_ptr <= rd_next;
            count  <= CNT_W'(1);
            if (keep_one) begin
                wr_ptr <= rd_next + PTR_W'(1);
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end else begin
            if (fetch) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({fetch, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.i_addr    = pc;
    assign bus.q_valid   = q_valid;
    assign bus.q_count   = count;
    assign bus.q_pc      = q_valid ? mem[rd_ptr].pc    : 32'h0;
    assign bus.q_instr   = q_valid ? mem[rd_ptr].instr : NOP;
    assign bus.q_exccode = q_valid ? mem[rd_ptr].exc   : EXC_NONE;
    assign bus.q_bd      = q_valid ? bd_mem[rd_ptr]    : 1'b0;
endmodule
